// File: rtl/path_probe_pkg.sv
// Shared types and helpers for the path latency probe sequencer.
package path_probe_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, WAIT, REPORT} state_e;

   localparam int DEF_N_PATHS    = 4;
   localparam int DEF_CNT_W      = 8;
   localparam int DEF_SETTLE_CYC = 4;
   localparam int DEF_TIMEOUT    = 200;

   typedef struct packed {
      logic exp_pre;
      logic exp_post;
   } levels_t;

   // Path output levels expected before and after the launch edge.
   function automatic levels_t exp_levels(input logic pol, input logic exp_inv);
      levels_t l;
      l.exp_pre  = ~pol ^ exp_inv;
      l.exp_post = pol ^ exp_inv;
      return l;
   endfunction

endpackage

// File: rtl/probe_cycle_counter.sv
// Cycle counter with load-to-1, increment and compare against a runtime limit.
module probe_cycle_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic             inc_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             hit_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = CNT_W'(1);
      else if (inc_i)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/path_probe_sequencer.sv
// Drives a pre-launch level on one path, launches an edge and measures the
// cycles until the path output reaches its expected level (or times out).
module path_probe_sequencer
   import path_probe_pkg::*;
#(
   parameter int N_PATHS    = DEF_N_PATHS,
   parameter int SEL_W      = (N_PATHS > 1) ? $clog2(N_PATHS) : 1,
   parameter int CNT_W      = DEF_CNT_W,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic               C,
   input  logic               RN,
   input  logic               START,
   input  logic [SEL_W-1:0]   SEL,
   input  logic               POL,
   input  logic               EXP_INV,
   input  logic [N_PATHS-1:0] Y_IN,
   output logic [N_PATHS-1:0] A_OUT,
   output logic               BUSY,
   output logic               DONE,
   output logic [CNT_W-1:0]   LAT,
   output logic               TMO,
   output logic               ERR
);

   if (TIMEOUT < 1 || TIMEOUT > (2**CNT_W) - 1) begin : g_bad_timeout
      $error("TIMEOUT must be in 1..2^CNT_W-1");
   end
   if (SETTLE_CYC < 1 || SETTLE_CYC > (2**CNT_W) - 1) begin : g_bad_settle
      $error("SETTLE_CYC must be in 1..2^CNT_W-1");
   end

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic               pol_q, pol_d;
   logic               inv_q, inv_d;
   logic [N_PATHS-1:0] aout_q, aout_d;
   logic [CNT_W-1:0]   lat_q, lat_d;
   logic               tmo_q, tmo_d;
   logic               err_q, err_d;

   logic               cnt_load, cnt_inc, cnt_hit;
   logic [CNT_W-1:0]   cnt, cnt_limit;
   logic [N_PATHS-1:0] in_hit, cur_hit;
   logic               sel_ok, y_sel;
   levels_t            lv;

   probe_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk_i   (C),
      .rst_ni  (RN),
      .load_i  (cnt_load),
      .inc_i   (cnt_inc),
      .limit_i (cnt_limit),
      .cnt_o   (cnt),
      .hit_o   (cnt_hit)
   );

   // One-hot decode of the requested and the captured path index.
   always_comb begin
      in_hit  = '0;
      cur_hit = '0;
      for (int i = 0; i < N_PATHS; i++) begin
         in_hit[i]  = (SEL == SEL_W'(i));
         cur_hit[i] = (sel_q == SEL_W'(i));
      end
   end

   assign sel_ok    = ({1'b0, SEL} < (SEL_W+1)'(N_PATHS));
   assign y_sel     = |(Y_IN & cur_hit);
   assign lv        = exp_levels(pol_q, inv_q);
   assign cnt_limit = (state_q == SETTLE) ? CNT_W'(SETTLE_CYC) : CNT_W'(TIMEOUT);

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      pol_d    = pol_q;
      inv_d    = inv_q;
      aout_d   = aout_q;
      lat_d    = lat_q;
      tmo_d    = tmo_q;
      err_d    = err_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (START) begin
               sel_d = SEL;
               pol_d = POL;
               inv_d = EXP_INV;
               tmo_d = 1'b0;
               err_d = 1'b0;
               if (!sel_ok) begin
                  err_d   = 1'b1;
                  state_d = REPORT;
               end else begin
                  aout_d   = (aout_q & ~in_hit) | (in_hit & {N_PATHS{~POL}});
                  cnt_load = 1'b1;
                  state_d  = SETTLE;
               end
            end
         end
         SETTLE: begin
            if (cnt_hit) begin
               // A path not sitting at its pre-level would give a bogus latency.
               if (y_sel != lv.exp_pre) begin
                  err_d   = 1'b1;
                  state_d = REPORT;
               end else begin
                  aout_d   = (aout_q & ~cur_hit) | (cur_hit & {N_PATHS{pol_q}});
                  cnt_load = 1'b1;
                  state_d  = WAIT;
               end
            end else begin
               cnt_inc = 1'b1;
            end
         end
         WAIT: begin
            if (y_sel == lv.exp_post) begin
               lat_d   = cnt;
               state_d = REPORT;
            end else if (cnt_hit) begin
               lat_d   = CNT_W'(TIMEOUT);
               tmo_d   = 1'b1;
               state_d = REPORT;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         state_q <= IDLE;
         sel_q   <= '0;
         pol_q   <= 1'b0;
         inv_q   <= 1'b0;
         aout_q  <= '0;
         lat_q   <= '0;
         tmo_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         pol_q   <= pol_d;
         inv_q   <= inv_d;
         aout_q  <= aout_d;
         lat_q   <= lat_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

   assign A_OUT = aout_q;
   assign BUSY  = (state_q != IDLE);
   assign DONE  = (state_q == REPORT);
   assign LAT   = lat_q;
   assign TMO   = tmo_q;
   assign ERR   = err_q;

endmodule

// File: tb/tb_path_probe_sequencer.sv
// Directed bench: one 4-path instance with a mix of path models, plus a
// 3-path instance for the out-of-range select abort.
module tb_path_probe_sequencer;

   logic       C = 1'b0;
   logic       RN;
   logic       START, POL, EXP_INV;
   logic [1:0] SEL;
   logic [3:0] Y_IN, A_OUT;
   logic       BUSY, DONE, TMO, ERR;
   logic [7:0] LAT;

   logic       START3, POL3, EXP_INV3;
   logic [1:0] SEL3;
   logic [2:0] Y_IN3, A_OUT3;
   logic       BUSY3, DONE3, TMO3, ERR3;
   logic [7:0] LAT3;

   logic       d1, d2;
   int         ed = 0;
   int         checks = 0;
   int         errors = 0;

   always #5 C = ~C;

   path_probe_sequencer #(.N_PATHS(4), .CNT_W(8), .SETTLE_CYC(4), .TIMEOUT(200)) dut (
      .C(C), .RN(RN), .START(START), .SEL(SEL), .POL(POL), .EXP_INV(EXP_INV),
      .Y_IN(Y_IN), .A_OUT(A_OUT), .BUSY(BUSY), .DONE(DONE), .LAT(LAT),
      .TMO(TMO), .ERR(ERR)
   );

   path_probe_sequencer #(.N_PATHS(3), .CNT_W(8), .SETTLE_CYC(4), .TIMEOUT(200)) dut3 (
      .C(C), .RN(RN), .START(START3), .SEL(SEL3), .POL(POL3), .EXP_INV(EXP_INV3),
      .Y_IN(Y_IN3), .A_OUT(A_OUT3), .BUSY(BUSY3), .DONE(DONE3), .LAT(LAT3),
      .TMO(TMO3), .ERR(ERR3)
   );

   // Path models: 0 stuck low, 1 combinational inverter, 2 two-flop delay
   // (first seen 3 edges after launch), 3 stuck high.
   always_ff @(posedge C or negedge RN) begin
      if (!RN) begin
         d1 <= 1'b0;
         d2 <= 1'b0;
      end else begin
         d1 <= A_OUT[2];
         d2 <= d1;
      end
   end
   assign Y_IN  = {1'b1, d2, ~A_OUT[1], 1'b0};
   assign Y_IN3 = 3'b000;

   task automatic go(input int e);
      while (ed < e) begin
         @(posedge C);
         ed++;
      end
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      RN = 1'b0; START = 1'b0; SEL = 2'd0; POL = 1'b0; EXP_INV = 1'b0;
      START3 = 1'b0; SEL3 = 2'd0; POL3 = 1'b0; EXP_INV3 = 1'b0;
      #2;
      chk("rst_aout", A_OUT, 4'b0000);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_done", DONE, 1'b0);
      chk("rst_lat", LAT, 8'd0);
      chk("rst_tmo", TMO, 1'b0);
      chk("rst_err", ERR, 1'b0);
      RN = 1'b1;

      // Scenario 1: delayed path, START at edge 10, launch at 14, match at 17.
      go(9);  SEL = 2'd2; POL = 1'b1; EXP_INV = 1'b0; START = 1'b1;
      go(10); START = 1'b0;
      chk("s1_busy_k", BUSY, 1'b1);
      chk("s1_pre", A_OUT, 4'b0000);
      go(13); chk("s1_pre_hold", A_OUT, 4'b0000);
      go(14); chk("s1_launch", A_OUT, 4'b0100);
      go(16); chk("s1_nodone16", DONE, 1'b0);
      go(17);
      chk("s1_done", DONE, 1'b1);
      chk("s1_lat", LAT, 8'd3);
      chk("s1_tmo", TMO, 1'b0);
      chk("s1_err", ERR, 1'b0);
      chk("s1_busy_rep", BUSY, 1'b1);
      go(18);
      chk("s1_done_off", DONE, 1'b0);
      chk("s1_busy_off", BUSY, 1'b0);
      chk("s1_lat_hold", LAT, 8'd3);
      chk("s1_aout_end", A_OUT, 4'b0100);

      // Scenario 5: rerun with START re-pulsed in WAIT and during REPORT.
      go(19); START = 1'b1;
      go(20); START = 1'b0;
      chk("s5_pre", A_OUT, 4'b0000);
      go(25); START = 1'b1;
      go(26); START = 1'b0;
      chk("s5_busy_wait", BUSY, 1'b1);
      chk("s5_nodone26", DONE, 1'b0);
      go(27);
      chk("s5_done", DONE, 1'b1);
      chk("s5_lat", LAT, 8'd3);
      START = 1'b1;
      go(28); START = 1'b0;
      chk("s5_rep_start_ign", BUSY, 1'b0);
      chk("s5_done_off", DONE, 1'b0);
      go(33);
      chk("s5_single_done", DONE, 1'b0);
      chk("s5_idle", BUSY, 1'b0);

      // Scenario 2: inverting zero-delay path, falling launch.
      go(39); SEL = 2'd1; POL = 1'b0; EXP_INV = 1'b1; START = 1'b1;
      go(40); START = 1'b0;
      chk("s2_pre", A_OUT, 4'b0110);
      go(44);
      chk("s2_launch", A_OUT, 4'b0100);
      chk("s2_nodone_L", DONE, 1'b0);
      go(45);
      chk("s2_done", DONE, 1'b1);
      chk("s2_lat", LAT, 8'd1);
      chk("s2_tmo", TMO, 1'b0);
      chk("s2_err", ERR, 1'b0);
      go(46); chk("s2_idle", BUSY, 1'b0);

      // Scenario 3: stuck-low path times out at L+200.
      go(49); SEL = 2'd0; POL = 1'b1; EXP_INV = 1'b0; START = 1'b1;
      go(50); START = 1'b0;
      chk("s3_pre", A_OUT, 4'b0100);
      go(54); chk("s3_launch", A_OUT, 4'b0101);
      go(253);
      chk("s3_nodone", DONE, 1'b0);
      chk("s3_busy", BUSY, 1'b1);
      go(254);
      chk("s3_done", DONE, 1'b1);
      chk("s3_tmo", TMO, 1'b1);
      chk("s3_lat", LAT, 8'd200);
      chk("s3_err", ERR, 1'b0);
      go(255);
      chk("s3_idle", BUSY, 1'b0);
      chk("s3_tmo_hold", TMO, 1'b1);

      // Scenario 4: stuck-high path fails the pre-level check at L.
      go(259); SEL = 2'd3; POL = 1'b1; EXP_INV = 1'b0; START = 1'b1;
      go(260); START = 1'b0;
      chk("s4_tmo_clr", TMO, 1'b0);
      chk("s4_err_clr", ERR, 1'b0);
      chk("s4_pre", A_OUT, 4'b0101);
      go(263); chk("s4_nodone", DONE, 1'b0);
      go(264);
      chk("s4_done", DONE, 1'b1);
      chk("s4_err", ERR, 1'b1);
      chk("s4_tmo", TMO, 1'b0);
      chk("s4_no_launch", A_OUT, 4'b0101);
      go(265);
      chk("s4_idle", BUSY, 1'b0);
      chk("s4_err_hold", ERR, 1'b1);

      // Scenario 4b: 3-path instance, SEL=3 aborts right after edge k.
      go(269); SEL3 = 2'd3; POL3 = 1'b1; START3 = 1'b1;
      go(270); START3 = 1'b0;
      chk("s4b_done", DONE3, 1'b1);
      chk("s4b_err", ERR3, 1'b1);
      chk("s4b_tmo", TMO3, 1'b0);
      chk("s4b_aout", A_OUT3, 3'b000);
      go(271);
      chk("s4b_done_off", DONE3, 1'b0);
      chk("s4b_idle", BUSY3, 1'b0);

      // Scenario 6: reset dropped in WAIT, then rerun of scenario 1.
      go(279); SEL = 2'd2; POL = 1'b1; EXP_INV = 1'b0; START = 1'b1;
      go(280); START = 1'b0;
      go(285);
      chk("s6_in_wait", BUSY, 1'b1);
      #3 RN = 1'b0;
      #1;
      chk("s6_rst_aout", A_OUT, 4'b0000);
      chk("s6_rst_busy", BUSY, 1'b0);
      chk("s6_rst_done", DONE, 1'b0);
      chk("s6_rst_lat", LAT, 8'd0);
      chk("s6_rst_tmo", TMO, 1'b0);
      chk("s6_rst_err", ERR, 1'b0);
      go(288); chk("s6_no_done", DONE, 1'b0);
      go(289); RN = 1'b1; START = 1'b1;
      go(290); START = 1'b0;
      chk("s6_busy_k", BUSY, 1'b1);
      chk("s6_pre", A_OUT, 4'b0000);
      go(294); chk("s6_launch", A_OUT, 4'b0100);
      go(297);
      chk("s6_done", DONE, 1'b1);
      chk("s6_lat", LAT, 8'd3);
      chk("s6_tmo", TMO, 1'b0);
      chk("s6_err", ERR, 1'b0);
      go(298);
      chk("s6_idle", BUSY, 1'b0);
      chk("s6_done_off", DONE, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/path_probe_sequencer.md
# path_probe_sequencer

Sequencer that measures the propagation latency, in clock cycles, of up to N_PATHS gate-level paths built from the library cells. For the selected path it:
- drives a pre-launch level and lets it settle;
- launches a single edge;
- counts cycles until the path output reaches the expected level, or until a timeout.

It sits between a test host (START/DONE handshake) and the path-under-test array (A_OUT drives path inputs, Y_IN returns path outputs).

## Interface
- N_PATHS, 4, number of probed paths
- SEL_W, $clog2(N_PATHS) (min 1), path-select width
- CNT_W, 8, latency counter width
- SETTLE_CYC, 4, pre-launch settle cycles (≥1)
- TIMEOUT, 200, max wait cycles (1..2^CNT_W−1)

Ports:
- C  in  1  clock, rising edge; one clock domain
- RN  in  1  reset, asynchronous, active-low
- START  in  1  request; sampled only in IDLE
- SEL  in  SEL_W  path index
- POL  in  1  launch edge: 1 = rising, 0 = falling
- EXP_INV  in  1  1 = path inverts
- Y_IN  in  N_PATHS  path outputs, synchronous to C
- A_OUT  out  N_PATHS  path input drives, registered
- BUSY  out  1  high whenever FSM ≠ IDLE
- DONE  out  1  one-cycle completion pulse
- LAT  out  CNT_W  measured cycles; valid with DONE, held until next DONE
- TMO  out  1  timeout flag; valid with DONE
- ERR  out  1  abort flag (bad SEL or stuck pre-level); valid with DONE

## Operation
- Reset (RN=0, asynchronous): FSM=IDLE; A_OUT, BUSY, DONE, LAT, TMO, ERR all 0.
- States: IDLE, SETTLE, WAIT, REPORT.
- Register set at start: SEL, POL, EXP_INV. pre = ~POL, exp_pre = pre^EXP_INV, exp_post = POL^EXP_INV.
- IDLE, START=1 at edge k:
  - SEL ≥ N_PATHS: go to REPORT with ERR=1. A_OUT unchanged.
  - Otherwise: A_OUT[SEL]=pre, settle counter=1, go to SETTLE.
- SETTLE: the counter increments each edge. On the edge where it equals SETTLE_CYC (the launch edge L = k+SETTLE_CYC):
  - Y_IN[SEL] ≠ exp_pre: go to REPORT, ERR=1, no launch. A_OUT[SEL] stays pre.
  - Otherwise: A_OUT[SEL]=POL, latency counter=1, go to WAIT.
- WAIT, each edge:
  - Y_IN[SEL]==exp_post: LAT=counter, go to REPORT.
  - Else, counter==TIMEOUT: LAT=TIMEOUT, TMO=1, go to REPORT.
  - Else: counter+1.
- REPORT: DONE=1 for exactly one cycle. Next edge: IDLE, DONE=0.
- A_OUT bits other than SEL are never changed. A_OUT[SEL] keeps its last driven level after completion.
- TMO, ERR and LAT are updated only on entry to REPORT. TMO and ERR clear when the next START is accepted.
- START while BUSY is ignored and not queued. START in the REPORT cycle is ignored.
- Counter never wraps: TIMEOUT ≤ 2^CNT_W−1 is an elaboration-time check.

## Timing
- Start latency: START sampled at edge k → BUSY=1 and A_OUT[SEL]=pre after edge k.
- Launch: A_OUT[SEL]=POL after edge L = k+SETTLE_CYC.
- Match first seen at edge L+d (d≥1): LAT=d, DONE high during cycle (L+d, L+d+1]. BUSY drops after edge L+d+1.
- A zero-delay path gives LAT=1.
- Timeout: DONE after edge L+TIMEOUT.
- Bad-SEL abort: DONE after edge k.
- Stuck-pre abort: DONE after edge L.
- Minimum START-to-START spacing: SETTLE_CYC+3 cycles.
- RN asserted mid-operation: outputs clear immediately, no DONE. After RN deasserts, the first START is honored on the first rising edge.

## Structure
- Package path_probe_pkg:
  - state enum (IDLE, SETTLE, WAIT, REPORT);
  - default parameter constants;
  - function computing expected levels from POL/EXP_INV.
- Sub-module probe_cycle_counter (CNT_W): load-1, increment, and terminal-compare against a runtime limit. Shared by SETTLE and WAIT.
- Top: FSM, request capture registers, A_OUT register, result registers.

## Test plan
Defaults: N_PATHS=4, CNT_W=8, SETTLE_CYC=4, TIMEOUT=200.
1. Y_IN[2] = A_OUT[2] delayed 3 cycles; SEL=2, POL=1, EXP_INV=0, START at edge 10 → A_OUT[2]=0 after edge 10, =1 after edge 14; DONE after edge 17; LAT=3, TMO=0, ERR=0; BUSY low after edge 18.
2. Y_IN[1] = ~A_OUT[1] combinational; SEL=1, POL=0, EXP_INV=1 → LAT=1, DONE after edge L+1, A_OUT[1] ends 0.
3. Y_IN[0] tied 0; SEL=0, POL=1, EXP_INV=0 → DONE after edge L+200, TMO=1, LAT=200, A_OUT[0]=1.
4. Y_IN[3] tied 1; SEL=3, POL=1, EXP_INV=0 → ERR=1 at edge k+4, A_OUT[3] stays 0, TMO=0. Separately, N_PATHS=3 with SEL=3 → DONE after edge k, ERR=1, A_OUT unchanged.
5. Re-pulse START during WAIT of scenario 1 → ignored, single DONE, LAT=3.
6. Drop RN during WAIT → all outputs 0 asynchronously, no DONE. After release, START reruns scenario 1 with the same result.
